// File: rtl/ps2_mouse_sequencer_if.sv
// PS/2 mouse sequencer bus bundle.
// PHY transmit/receive, user command and stream signals.
interface ps2_mouse_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_ack;
  logic       tx_error;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_err;
  logic [7:0] stream_data;
  logic       stream_valid;

  modport master (
    output tx_data, tx_start, cmd_ready, cmd_done, cmd_err,
    output stream_data, stream_valid,
    input  tx_busy, tx_ack, tx_error, rx_data, rx_ready,
    input  cmd_valid, cmd_data
  );

  modport slave (
    input  tx_data, tx_start, cmd_ready, cmd_done, cmd_err,
    input  stream_data, stream_valid,
    output tx_busy, tx_ack, tx_error, rx_data, rx_ready,
    output cmd_valid, cmd_data
  );
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse init sequencer: reset, BAT/ID, rate, enable.
// Then streams movement bytes and arbitrates user commands.
module ps2_mouse_sequencer #(
  parameter int         POWERUP_DELAY = 2700000,
  parameter int         RESP_TIMEOUT  = 540000,
  parameter int         BAT_TIMEOUT   = 27000000,
  parameter int         MAX_RETRY     = 3,
  parameter logic [7:0] SAMPLE_RATE   = 8'd100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ps2_mouse_sequencer_if.master         bus,
  output logic                          init_done_o,
  output logic                          fail_o,
  output logic [3:0]                    state_o,
  output logic [3:0]                    retry_count_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_POWERUP = 4'd1,
    S_SEND    = 4'd2,
    S_TX_WAIT = 4'd3,
    S_RESP    = 4'd4,
    S_BAT     = 4'd5,
    S_ID      = 4'd6,
    S_STREAM  = 4'd7,
    S_FAIL    = 4'd8
  } state_e;

  localparam logic [31:0] PD_L  = 32'(POWERUP_DELAY - 1);
  localparam logic [31:0] RT_L  = 32'(RESP_TIMEOUT - 1);
  localparam logic [31:0] BT_L  = 32'(BAT_TIMEOUT - 1);
  localparam logic [3:0]  MAX_R = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] timer_q, timer_d;
  logic        seen_q, seen_d;
  logic [7:0]  cbyte_q, cbyte_d;
  logic [7:0]  txd_q, txd_d;
  logic        txs_q, txs_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  sd_q, sd_d;
  logic        sv_q, sv_d;
  logic        init_q, init_d;
  logic        fail_q, fail_d;
  logic [7:0]  step_byte;
  logic        expired;
  logic        att_fail;

  // Byte sent for the current step.
  always_comb begin
    step_byte = cbyte_q;
    unique case (step_q)
      3'd0:    step_byte = 8'hFF;
      3'd1:    step_byte = 8'hF3;
      3'd2:    step_byte = SAMPLE_RATE;
      3'd3:    step_byte = 8'hF4;
      default: step_byte = cbyte_q;
    endcase
  end

  // Next-state, retry policy, timer reload and output pulses.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    seen_d   = seen_q;
    cbyte_d  = cbyte_q;
    txd_d    = txd_q;
    txs_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    sd_d     = sd_q;
    sv_d     = 1'b0;
    att_fail = 1'b0;
    expired  = (timer_q == 32'd0);

    unique case (state_q)
      S_IDLE: state_d = S_POWERUP;
      S_POWERUP: begin
        if (expired) begin
          state_d = S_SEND;
          step_d  = 3'd0;
        end
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          txs_d   = 1'b1;
          txd_d   = step_byte;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (seen_q && !bus.tx_busy) begin
          if (bus.tx_ack && !bus.tx_error) state_d = S_RESP;
          else att_fail = 1'b1;
        end else if (expired) begin
          att_fail = 1'b1;
        end else if (bus.tx_busy) begin
          seen_d = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rx_ready) begin
          if (bus.rx_data == 8'hFA) begin
            unique case (step_q)
              3'd0: state_d = S_BAT;
              3'd1, 3'd2: begin
                state_d = S_SEND;
                step_d  = step_q + 3'd1;
                retry_d = 4'd0;
              end
              3'd3: state_d = S_STREAM;
              default: begin
                done_d  = 1'b1;
                state_d = S_STREAM;
              end
            endcase
          end else if (bus.rx_data == 8'hFE || bus.rx_data == 8'hFC) begin
            att_fail = 1'b1;
          end
        end else if (expired) begin
          att_fail = 1'b1;
        end
      end
      S_BAT: begin
        if (bus.rx_ready) begin
          if (bus.rx_data == 8'hAA) state_d = S_ID;
          else att_fail = 1'b1;
        end else if (expired) begin
          att_fail = 1'b1;
        end
      end
      S_ID: begin
        if (bus.rx_ready) begin
          state_d = S_SEND;
          step_d  = 3'd1;
          retry_d = 4'd0;
        end else if (expired) begin
          att_fail = 1'b1;
        end
      end
      S_STREAM: begin
        if (bus.rx_ready) begin
          sd_d = bus.rx_data;
          sv_d = 1'b1;
        end
        if (bus.cmd_valid) begin
          cbyte_d = bus.cmd_data;
          step_d  = 3'd4;
          state_d = S_SEND;
        end
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase

    if (att_fail) begin
      if (retry_q < MAX_R) begin
        retry_d = retry_q + 4'd1;
        state_d = S_SEND;
      end else if (step_q == 3'd4) begin
        err_d   = 1'b1;
        state_d = S_STREAM;
      end else begin
        state_d = S_FAIL;
      end
    end

    if (state_d == S_STREAM) retry_d = 4'd0;

    if (state_d != state_q) begin
      seen_d = 1'b0;
      unique case (state_d)
        S_POWERUP:               timer_d = PD_L;
        S_TX_WAIT, S_RESP, S_ID: timer_d = RT_L;
        S_BAT:                   timer_d = BT_L;
        default:                 timer_d = 32'd0;
      endcase
    end else if (!expired) begin
      timer_d = timer_q - 32'd1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      retry_q <= 4'd0;
      timer_q <= 32'd0;
      seen_q  <= 1'b0;
      cbyte_q <= 8'h00;
      txd_q   <= 8'h00;
      txs_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sd_q    <= 8'h00;
      sv_q    <= 1'b0;
      init_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      seen_q  <= seen_d;
      cbyte_q <= cbyte_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      init_q  <= init_d;
      fail_q  <= fail_d;
    end
  end

  // Status flags decoded from the next state.
  always_comb begin
    init_d = (state_d == S_STREAM);
    fail_d = (state_d == S_FAIL);
  end

  assign bus.tx_data      = txd_q;
  assign bus.tx_start     = txs_q;
  assign bus.cmd_ready    = init_q;
  assign bus.cmd_done     = done_q;
  assign bus.cmd_err      = err_q;
  assign bus.stream_data  = sd_q;
  assign bus.stream_valid = sv_q;
  assign init_done_o      = init_q;
  assign fail_o           = fail_q;
  assign state_o          = state_q;
  assign retry_count_o    = retry_q;

endmodule
